// File: rtl/sia_dmac_pkg.sv
// sia_dmac_pkg: shared definitions for the SIA DMA controller.
//   state_e  - 3-bit channel sequencer state encoding
//   SEL_WORD - byte-select pattern for 16-bit word transfers
package sia_dmac_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_RD_REQ = 3'd2,
      ST_RD_ACK = 3'd3,
      ST_WR_REQ = 3'd4,
      ST_WR_ACK = 3'd5,
      ST_FIN    = 3'd6
   } state_e;

   localparam logic [1:0] SEL_WORD = 2'b11;

endpackage

// File: rtl/sia_dmac.sv
// sia_dmac: single-channel DMA controller for the serial interface adapter.
// Moves count_i 16-bit words between the SIA data register and memory as a
// Wishbone B4 pipelined master, one bus cycle outstanding at a time.
//   clk_i, reset_i             clock, async active-high reset
//   start_i, abort_i           channel control pulses
//   dir_i, mem_adr_i, count_i  transfer setup (0 = RX SIA->mem, 1 = TX mem->SIA)
//   rx_not_empty_i, tx_not_full_i  SIA queue flags
//   adr_o, we_o, cyc_o, stb_o, sel_o, dat_o, dat_i, ack_i, stall_i  WB master
//   busy_o, done_o, aborted_o, remaining_o  channel status
module sia_dmac
   import sia_dmac_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH   = 24,
   parameter int unsigned            COUNT_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0]  SIA_DATA_ADR = '0
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   dir_i,
   input  logic [ADDR_WIDTH-1:0]  mem_adr_i,
   input  logic [COUNT_WIDTH-1:0] count_i,
   input  logic                   rx_not_empty_i,
   input  logic                   tx_not_full_i,
   output logic [ADDR_WIDTH-1:0]  adr_o,
   output logic                   we_o,
   output logic                   cyc_o,
   output logic                   stb_o,
   output logic [1:0]             sel_o,
   output logic [15:0]            dat_o,
   input  logic [15:0]            dat_i,
   input  logic                   ack_i,
   input  logic                   stall_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   aborted_o,
   output logic [COUNT_WIDTH-1:0] remaining_o
);

   state_e                 state_q;
   logic                   dir_q;
   logic [ADDR_WIDTH-1:0]  ptr_q;
   logic [ADDR_WIDTH-1:0]  ptr_d;
   logic [COUNT_WIDTH-1:0] rem_q;
   logic [COUNT_WIDTH-1:0] rem_d;
   logic [15:0]            hold_q;
   logic                   abort_q;
   logic                   abort_hit;
   logic                   flag_ok;
   logic [ADDR_WIDTH-1:0]  adr_q;
   logic                   we_q;
   logic                   cyc_q;
   logic                   stb_q;
   logic [1:0]             sel_q;
   logic [15:0]            dat_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   aborted_q;

   always_comb begin
      ptr_d     = ptr_q + ADDR_WIDTH'(1);
      rem_d     = rem_q - COUNT_WIDTH'(1);
      abort_hit = abort_q | abort_i;
      flag_ok   = dir_q ? tx_not_full_i : rx_not_empty_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         dir_q     <= 1'b0;
         ptr_q     <= '0;
         rem_q     <= '0;
         hold_q    <= '0;
         abort_q   <= 1'b0;
         adr_q     <= '0;
         we_q      <= 1'b0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         sel_q     <= '0;
         dat_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  dir_q     <= dir_i;
                  ptr_q     <= mem_adr_i;
                  rem_q     <= count_i;
                  aborted_q <= 1'b0;
                  abort_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= (count_i == '0) ? ST_FIN : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (abort_i) begin
                  aborted_q <= 1'b1;
                  state_q   <= ST_FIN;
               end else if (flag_ok) begin
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  we_q    <= 1'b0;
                  sel_q   <= SEL_WORD;
                  adr_q   <= dir_q ? ptr_q : SIA_DATA_ADR;
                  state_q <= ST_RD_REQ;
               end
            end
            ST_RD_REQ: begin
               if (abort_i) abort_q <= 1'b1;
               if (!stall_i) begin
                  stb_q   <= 1'b0;
                  sel_q   <= '0;
                  state_q <= ST_RD_ACK;
               end
            end
            ST_RD_ACK: begin
               if (abort_i) abort_q <= 1'b1;
               if (ack_i) begin
                  hold_q  <= dat_i;
                  cyc_q   <= 1'b0;
                  state_q <= ST_WR_REQ;
               end
            end
            ST_WR_REQ: begin
               if (abort_i) abort_q <= 1'b1;
               // First cycle here is the one-cycle cyc_o gap after the read;
               // the write request is raised at its end.
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  we_q  <= 1'b1;
                  sel_q <= SEL_WORD;
                  adr_q <= dir_q ? SIA_DATA_ADR : ptr_q;
                  dat_q <= hold_q;
               end else if (!stall_i) begin
                  stb_q   <= 1'b0;
                  sel_q   <= '0;
                  state_q <= ST_WR_ACK;
               end
            end
            ST_WR_ACK: begin
               if (ack_i) begin
                  cyc_q <= 1'b0;
                  we_q  <= 1'b0;
                  ptr_q <= ptr_d;
                  rem_q <= rem_d;
                  if ((rem_d == '0) || abort_hit) begin
                     aborted_q <= abort_hit;
                     state_q   <= ST_FIN;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end else if (abort_i) begin
                  abort_q <= 1'b1;
               end
            end
            ST_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               abort_q <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign adr_o       = adr_q;
   assign we_o        = we_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = stb_q;
   assign sel_o       = sel_q;
   assign dat_o       = dat_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign aborted_o   = aborted_q;
   assign remaining_o = rem_q;

endmodule

// File: tb/tb_sia_dmac.sv
// tb_sia_dmac: directed, table-driven bench for sia_dmac with a Wishbone
// slave model that serves SIA reads from a counting data source and memory
// reads from an address-derived pattern, logging every accepted request.
module tb_sia_dmac;

   localparam logic [23:0] SIA = 24'hC00010;

   typedef struct {
      logic        we;
      logic [23:0] adr;
      logic [15:0] dat;
   } txn_t;

   typedef struct {
      logic        dir;
      logic [23:0] adr;
      logic [15:0] count;
      logic [15:0] rx_base;
      int          stall;
      int          flag_delay;
      int          abort_word;
      int          exp_words;
      logic [15:0] exp_rem;
      logic        exp_ab;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_i, start_i, abort_i, dir_i;
   logic [23:0] mem_adr_i;
   logic [15:0] count_i;
   logic        rx_not_empty_i, tx_not_full_i;
   logic [23:0] adr_o;
   logic        we_o, cyc_o, stb_o;
   logic [1:0]  sel_o;
   logic [15:0] dat_o;
   logic [15:0] dat_i;
   logic        ack_i, stall_i;
   logic        busy_o, done_o, aborted_o;
   logic [15:0] remaining_o;

   int n_cmp = 0;
   int n_fail = 0;

   // slave model state
   txn_t        log_q[$];
   int          stall_cfg = 0;
   int          stall_cnt;
   int          rx_idx = 0;
   int          rx_idx0 = 0;
   int          rd_acc = 0;
   logic [15:0] rx_base = '0;
   logic        p_stall;
   txn_t        p_txn;

   sia_dmac #(
      .ADDR_WIDTH  (24),
      .COUNT_WIDTH (16),
      .SIA_DATA_ADR(SIA)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .dir_i         (dir_i),
      .mem_adr_i     (mem_adr_i),
      .count_i       (count_i),
      .rx_not_empty_i(rx_not_empty_i),
      .tx_not_full_i (tx_not_full_i),
      .adr_o         (adr_o),
      .we_o          (we_o),
      .cyc_o         (cyc_o),
      .stb_o         (stb_o),
      .sel_o         (sel_o),
      .dat_o         (dat_o),
      .dat_i         (dat_i),
      .ack_i         (ack_i),
      .stall_i       (stall_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .aborted_o     (aborted_o),
      .remaining_o   (remaining_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   assign stall_i = stb_o && (stall_cnt < stall_cfg);

   // Wishbone slave: ack one cycle after acceptance.
   always @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         ack_i     <= 1'b0;
         dat_i     <= '0;
         stall_cnt <= 0;
         p_stall   <= 1'b0;
      end else begin
         ack_i   <= 1'b0;
         p_stall <= stb_o && stall_i;
         if (stb_o && p_stall)
            check("stall_stable", 64'({we_o, adr_o, dat_o}), 64'({p_txn.we, p_txn.adr, p_txn.dat}));
         if (stb_o) begin
            p_txn <= '{we: we_o, adr: adr_o, dat: dat_o};
            if (stall_i) begin
               stall_cnt <= stall_cnt + 1;
            end else begin
               stall_cnt <= 0;
               check("sel", 64'(sel_o), 64'(2'b11));
               log_q.push_back('{we: we_o, adr: adr_o, dat: dat_o});
               ack_i <= 1'b1;
               if (!we_o) begin
                  rd_acc <= rd_acc + 1;
                  if (adr_o == SIA) begin
                     dat_i  <= rx_base + 16'(rx_idx - rx_idx0);
                     rx_idx <= rx_idx + 1;
                  end else begin
                     dat_i <= adr_o[15:0] ^ 16'h5A5A;
                  end
               end
            end
         end
      end
   end

   task automatic run_vec(input string nm, input vec_t v);
      int   lg0, rd0, early;
      bit   seen, ab_sent;
      txn_t t;
      logic [23:0] madr;
      stall_cfg = v.stall;
      rx_base   = v.rx_base;
      rx_idx0   = rx_idx;
      rd0       = rd_acc;
      lg0       = log_q.size();
      rx_not_empty_i = (v.flag_delay == 0);
      tx_not_full_i  = (v.flag_delay == 0);
      dir_i     = v.dir;
      mem_adr_i = v.adr;
      count_i   = v.count;
      start_i   = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      seen = 0; ab_sent = 0; early = 0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         if (c == v.flag_delay) begin
            rx_not_empty_i = 1'b1;
            tx_not_full_i  = 1'b1;
         end
         if (v.abort_word != 0 && !ab_sent && (rd_acc - rd0) == v.abort_word) begin
            abort_i = 1'b1;
            ab_sent = 1;
         end
         @(posedge clk); #1;
         abort_i = 1'b0;
         if (c < v.flag_delay && cyc_o) early++;
         if (done_o) seen = 1;
      end
      check({nm, "_done"}, 64'(seen), 64'(1));
      check({nm, "_rem"}, 64'(remaining_o), 64'(v.exp_rem));
      check({nm, "_aborted"}, 64'(aborted_o), 64'(v.exp_ab));
      check({nm, "_busy_at_done"}, 64'(busy_o), 64'(0));
      if (v.flag_delay > 0) check({nm, "_no_cyc_while_flag_low"}, 64'(early), 64'(0));
      @(posedge clk); #1;
      check({nm, "_done_one_cycle"}, 64'(done_o), 64'(0));
      check({nm, "_ntxn"}, 64'(log_q.size() - lg0), 64'(2 * v.exp_words));
      if (log_q.size() >= lg0 + 2 * v.exp_words) begin
         for (int i = 0; i < v.exp_words; i++) begin
            madr = v.adr + 24'(i);
            t = log_q[lg0 + 2*i];
            check($sformatf("%s_rd%0d", nm, i), 64'({t.we, t.adr}), 64'({1'b0, v.dir ? madr : SIA}));
            t = log_q[lg0 + 2*i + 1];
            check($sformatf("%s_wr%0d", nm, i), 64'({t.we, t.adr, t.dat}),
                  64'({1'b1, v.dir ? SIA : madr,
                       v.dir ? (madr[15:0] ^ 16'h5A5A) : (v.rx_base + 16'(i))}));
         end
      end
   endtask

   initial begin
      vec_t vecs[5];
      bit   hit;
      vecs[0] = '{1'b0, 24'h001000, 16'd3, 16'h00A1, 0, 0,  0, 3, 16'd0, 1'b0};
      vecs[1] = '{1'b1, 24'h002000, 16'd2, 16'h0000, 0, 10, 0, 2, 16'd0, 1'b0};
      vecs[2] = '{1'b0, 24'h001000, 16'd3, 16'h00A1, 4, 0,  0, 3, 16'd0, 1'b0};
      vecs[3] = '{1'b1, 24'hFFFFFF, 16'd2, 16'h0000, 4, 3,  0, 2, 16'd0, 1'b0};
      vecs[4] = '{1'b0, 24'h003000, 16'd5, 16'h0B00, 0, 0,  2, 2, 16'd3, 1'b1};

      reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; dir_i = 1'b0;
      mem_adr_i = '0; count_i = '0; rx_not_empty_i = 1'b0; tx_not_full_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(posedge clk); #1;
      check("rst_bus", 64'({cyc_o, stb_o, we_o, sel_o}), 64'(0));
      check("rst_adr_dat", 64'({adr_o, dat_o}), 64'(0));
      check("rst_status", 64'({busy_o, done_o, aborted_o, remaining_o}), 64'(0));

      for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // zero-length run: busy exactly one cycle, done two cycles after start
      dir_i = 1'b0; mem_adr_i = 24'h005000; count_i = '0; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      check("cnt0_c1", 64'({busy_o, done_o, cyc_o}), 64'(3'b100));
      check("cnt0_aborted_cleared", 64'(aborted_o), 64'(0));
      @(posedge clk); #1;
      check("cnt0_c2", 64'({busy_o, done_o, cyc_o}), 64'(3'b010));
      check("cnt0_rem", 64'(remaining_o), 64'(0));
      @(posedge clk); #1;
      check("cnt0_c3", 64'({busy_o, done_o, cyc_o}), 64'(3'b000));

      // reset asserted while a stalled write request is on the bus
      stall_cfg = 6; rx_base = 16'h1234; rx_idx0 = rx_idx;
      rx_not_empty_i = 1'b1;
      dir_i = 1'b0; mem_adr_i = 24'h004000; count_i = 16'd3; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(posedge clk); #1;
         if (stb_o && we_o) hit = 1;
      end
      check("rst_mid_reached_wr_req", 64'(hit), 64'(1));
      #2 reset_i = 1'b1;
      #1;
      check("rst_mid_bus", 64'({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o}), 64'(0));
      check("rst_mid_status", 64'({busy_o, done_o, aborted_o, remaining_o}), 64'(0));
      @(posedge clk); #1 reset_i = 1'b0;
      @(posedge clk); #1;
      run_vec("after_rst", vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sia_dmac.md
Name: sia_dmac

Overview:
- Single-channel DMA controller that services the serial interface adapter's receive-not-empty and transmit-not-full flags.
- Acts as a Wishbone B4 pipelined bus master, one transfer at a time. Each transfer is either a SIA data-register read followed by a memory write (RX), or a memory read followed by a SIA data-register write (TX).
- The CPU configures it through plain control ports driven by a register block. It moves count_i 16-bit words, then reports completion.

Parameters:
- ADDR_WIDTH, 24, width of the word-address bus; master address is adr_o[ADDR_WIDTH:1].
- COUNT_WIDTH, 16, width of the transfer counter.
- SIA_DATA_ADR, 24'h000000, word address (bits [ADDR_WIDTH:1]) of the SIA data register.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; latches dir_i, mem_adr_i, count_i when idle
- abort_i  in  1  one-cycle pulse; stops the channel after the current bus cycle
- dir_i  in  1  0 = RX (SIA to memory), 1 = TX (memory to SIA)
- mem_adr_i  in  ADDR_WIDTH  starting memory word address
- count_i  in  COUNT_WIDTH  number of words to move
- rx_not_empty_i  in  1  SIA receive queue holds data
- tx_not_full_i  in  1  SIA transmit queue has room
- adr_o  out  ADDR_WIDTH  master word address
- we_o  out  1  master write enable
- cyc_o  out  1  master cycle
- stb_o  out  1  master strobe
- sel_o  out  2  byte selects; always 2'b11 while stb_o is high
- dat_o  out  16  master write data
- dat_i  in  16  master read data
- ack_i  in  1  slave acknowledge
- stall_i  in  1  slave stall
- busy_o  out  1  channel active
- done_o  out  1  one-cycle pulse when the channel returns to idle
- aborted_o  out  1  high if the last run ended by abort; cleared on start
- remaining_o  out  COUNT_WIDTH  words left to move

Behaviour:
- Reset values (asynchronous on reset_i high): state IDLE; all bus outputs 0; busy_o, done_o, aborted_o 0; remaining_o 0; internal pointer and holding register 0.
- States: IDLE, WAIT, RD_REQ, RD_ACK, WR_REQ, WR_ACK, FIN.
- IDLE:
  - start_i latches dir, pointer = mem_adr_i, remaining = count_i, clears aborted_o.
  - count_i == 0: go to FIN. Otherwise go to WAIT.
  - start_i while not IDLE is ignored.
- WAIT:
  - RX proceeds when rx_not_empty_i = 1; TX proceeds when tx_not_full_i = 1. Then go to RD_REQ.
  - abort_i in WAIT: set aborted_o, go to FIN.
- RD_REQ:
  - cyc_o = stb_o = 1, we_o = 0.
  - adr_o = SIA_DATA_ADR (RX) or pointer (TX).
  - Hold while stall_i = 1; on stall_i = 0 drop stb_o, go to RD_ACK.
- RD_ACK:
  - cyc_o held; on ack_i, capture dat_i into holding register, drop cyc_o for one cycle, go to WR_REQ.
- WR_REQ:
  - cyc_o = stb_o = we_o = 1, dat_o = holding register.
  - adr_o = pointer (RX) or SIA_DATA_ADR (TX).
  - Same stall rule as RD_REQ; then go to WR_ACK.
- WR_ACK:
  - On ack_i: drop cyc_o, pointer += 1 (wraps modulo 2^ADDR_WIDTH), remaining -= 1.
  - remaining becomes 0: FIN. Otherwise WAIT.
- Abort latching:
  - abort_i in any bus state is latched.
  - The bus cycle in progress completes, including the pending write of a word already read, so no data is lost.
  - Then go to FIN with aborted_o = 1. remaining_o reflects words actually written.
- FIN: done_o = 1 for one cycle, busy_o = 0 next cycle, return to IDLE.
- busy_o = 1 in every state except IDLE.
- Flags are sampled only in WAIT, so one word moves per flag observation; the minimum gap between transfers is one WAIT cycle, which covers the flag update latency.
- No more than one bus cycle outstanding; cyc_o never asserts while idle.
- Asserting reset_i mid-transfer abandons the cycle immediately; cyc_o/stb_o drop asynchronously.

Decomposition:
- Shared package holds the state encoding (3-bit enum) and the SEL_WORD = 2'b11 constant.
- No sub-module; the bus sequencer and counters form one FSM.

Test Plan:
- RX, count 3, mem_adr 24'h001000, SIA returns 16'hA1, A2, A3 with rx_not_empty_i high -> memory writes at 24'h001000/1001/1002 with those data, done_o pulse, remaining_o 0.
- TX, count 2, tx_not_full_i low for 10 cycles then high -> no cyc_o for 10 cycles; then memory reads followed by SIA writes of the same data, done_o after 2 words.
- count_i 0 -> no bus activity, done_o pulse 2 cycles after start_i, busy_o high for exactly 1 cycle.
- stall_i held 4 cycles on every request -> stb_o held with stable adr_o/dat_o/we_o; transfer results identical to the no-stall run.
- abort_i during RD_ACK of word 2 of 5 (RX) -> word 2 still written to memory, aborted_o = 1, remaining_o = 3, done_o pulse.
- reset_i asserted mid-WR_REQ -> all outputs 0 asynchronously; a subsequent start_i runs normally.
